// File: rtl/wave_sample_poller.sv
// wave_sample_poller: polls a sample PIO over Avalon-MM at a set interval
// and streams the captured samples out of a registered-output FIFO.

module wave_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          pop;
  logic          accept;

  assign pop     = valid & ready;
  assign accept  = push & ((count != FULL) | pop);
  assign dropped = push & ~accept;
  assign rd_nxt  = rd_ptr + PTR_ONE;

  always_comb begin
    count_nxt = count;
    unique case ({accept, pop})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

  // dout is the registered head; it moves only on a pop or a push into empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_nxt;
      count <= count_nxt;
      valid <= (count_nxt != '0);
      if (pop && count > ONE)
        dout <= mem[rd_nxt];
      else if (accept && (pop || count == '0))
        dout <= din;
    end
  end

endmodule

module wave_sample_poller #(
  parameter int SAMPLE_ADDR = 0,
  parameter int SAMPLE_W    = 16,
  parameter int DEPTH       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         num_samples,
  input  logic [15:0]         period,
  output logic [1:0]          avm_address,
  output logic                avm_read,
  input  logic [31:0]         avm_readdata,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    WAIT
  } state_t;

  state_t      state;
  logic [15:0] num_q;
  logic [15:0] eff_q;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [15:0] wait_cnt;
  logic        abort_pend;
  logic        fifo_push;
  logic        fifo_drop;
  logic        unused_hi;

  assign avm_address = 2'(SAMPLE_ADDR);
  assign fifo_push   = (state == CAPTURE);
  assign cnt_inc     = cnt + 16'd1;
  assign unused_hi   = ^avm_readdata[31:SAMPLE_W];

  wave_sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .din     (avm_readdata[SAMPLE_W-1:0]),
    .ready   (out_ready),
    .dout    (out_data),
    .valid   (out_valid),
    .dropped (fifo_drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      avm_read   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      num_q      <= '0;
      eff_q      <= 16'd2;
      cnt        <= '0;
      wait_cnt   <= '0;
      abort_pend <= 1'b0;
    end else begin
      done     <= 1'b0;
      avm_read <= 1'b0;
      if (fifo_drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hff)
          drop_count <= drop_count + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            num_q      <= num_samples;
            eff_q      <= (period < 16'd2) ? 16'd2 : period;
            cnt        <= '0;
            abort_pend <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            if (num_samples == '0) begin
              done <= 1'b1;
            end else begin
              busy     <= 1'b1;
              avm_read <= 1'b1;
              state    <= READ;
            end
          end
        end
        READ: begin
          if (abort) abort_pend <= 1'b1;
          state <= CAPTURE;
        end
        CAPTURE: begin
          cnt <= cnt_inc;
          if (cnt_inc == num_q || abort || abort_pend) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (eff_q > 16'd2) begin
            state    <= WAIT;
            wait_cnt <= eff_q - 16'd3;
          end else begin
            state    <= READ;
            avm_read <= 1'b1;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (wait_cnt == '0) begin
            state    <= READ;
            avm_read <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_sample_poller.sv
// tb_wave_sample_poller: directed vectors plus hand sequences for
// overflow, full-with-pop, abort and mid-burst reset.

module tb_wave_sample_poller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_samples = '0;
  logic [15:0] period = '0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [7:0]  drop_count;

  wave_sample_poller dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_samples  (num_samples),
    .period       (period),
    .avm_address  (avm_address),
    .avm_read     (avm_read),
    .avm_readdata (avm_readdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int num;
    int per;
    int abort_at;
    int restart_at;
    int exp_reads;
    int exp_step;
    int exp_done;
  } vec_t;

  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          first_ov = -1;
  logic        b1 = 1'b0;
  logic        rd_prev = 1'b0;
  logic [15:0] next_val = 16'h1111;
  int          rd_cyc[$];
  int          done_cyc[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock; pops are recorded before the edge, outputs after it
  task automatic step();
    if (out_valid && out_ready) got_q.push_back(out_data);
    @(posedge clk);
    #1;
    cyc++;
    if (avm_read) rd_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (out_valid && first_ov < 0) first_ov = cyc - t0;
    if (cyc == t0 + 1) b1 = busy;
    if (rd_prev) begin
      avm_readdata = {16'hA5C3, next_val};
      exp_q.push_back(next_val);
      next_val = next_val + 16'h1111;
    end else begin
      avm_readdata = 32'hFFFF_0BAD;
    end
    rd_prev = avm_read;
  endtask

  function automatic int seq_bad();
    int bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic run(input int num, input int per, input int abort_at,
                     input int restart_at, input logic rdy,
                     input int pulse_at);
    got_q.delete();
    exp_q.delete();
    rd_cyc.delete();
    done_cyc.delete();
    first_ov = -1;
    next_val = 16'h1111;
    t0 = cyc;
    num_samples = 16'(num);
    period = 16'(per);
    out_ready = rdy;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && done_cyc.size() == 0; i++) begin
      abort = (cyc - t0 == abort_at);
      start = (cyc - t0 == restart_at);
      out_ready = rdy | (cyc - t0 == pulse_at);
      step();
    end
    abort = 1'b0;
    start = 1'b0;
    out_ready = rdy;
    chk("done_seen", done_cyc.size() > 0, 1);
  endtask

  task automatic chk_burst(input int er, input int es, input int ed);
    int bad = 0;
    repeat (3) step();
    chk("read_count", rd_cyc.size(), er);
    if (er > 0 && rd_cyc.size() > 0) begin
      chk("first_read", rd_cyc[0] - t0, 1);
      chk("first_valid", first_ov, 3);
    end
    chk("busy_t1", b1, er > 0);
    for (int i = 1; i < rd_cyc.size(); i++)
      if (rd_cyc[i] - rd_cyc[i-1] != es) bad++;
    chk("read_spacing", bad, 0);
    chk("done_cycle", done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, ed);
    chk("done_pulses", done_cyc.size(), 1);
    chk("busy_after", busy, 0);
    chk("overflow_clr", overflow, 0);
    chk("out_count", got_q.size(), er);
    chk("out_data_seq", seq_bad(), 0);
  endtask

  task automatic chk_reset_state();
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
  endtask

  initial begin
    vecs[0]  = '{4, 5, -1, -1, 4, 5, 18};
    vecs[1]  = '{3, 0, -1, -1, 3, 2, 7};
    vecs[2]  = '{3, 1, -1, -1, 3, 2, 7};
    vecs[3]  = '{3, 2, -1, -1, 3, 2, 7};
    vecs[4]  = '{2, 3, -1, -1, 2, 3, 6};
    vecs[5]  = '{0, 5, -1, -1, 0, 0, 1};
    vecs[6]  = '{1, 7, -1, -1, 1, 0, 3};
    vecs[7]  = '{10, 4, 11, -1, 3, 4, 12};
    vecs[8]  = '{10, 4, 5, -1, 2, 4, 7};
    vecs[9]  = '{10, 4, 6, -1, 2, 4, 7};
    vecs[10] = '{3, 4, -1, 3, 3, 4, 11};
    vecs[11] = '{2, 16, -1, -1, 2, 16, 19};

    reset = 1'b1;
    repeat (2) step();
    chk_reset_state();
    reset = 1'b0;
    step();

    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("idle_abort_done", done, 0);
    chk("idle_abort_busy", busy, 0);

    foreach (vecs[v]) begin
      run(vecs[v].num, vecs[v].per, vecs[v].abort_at,
          vecs[v].restart_at, 1'b1, -1);
      chk_burst(vecs[v].exp_reads, vecs[v].exp_step, vecs[v].exp_done);
    end

    // overflow: nothing drained during the burst
    run(20, 2, -1, -1, 1'b0, -1);
    chk("ovf_done_cycle", done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, 41);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 4);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_head_stable", out_data, 16'h1111);
    out_ready = 1'b1;
    repeat (20) step();
    chk("ovf_drain_count", got_q.size(), 16);
    chk("ovf_drain_seq", seq_bad(), 0);
    chk("ovf_drained_valid", out_valid, 0);

    // full FIFO with a pop in the 17th capture cycle
    run(20, 2, -1, -1, 1'b0, 34);
    chk("fullpop_drops", drop_count, 3);
    chk("fullpop_flag", overflow, 1);
    chk("fullpop_popped", got_q.size(), 1);
    out_ready = 1'b1;
    repeat (20) step();
    chk("fullpop_count", got_q.size(), 17);
    chk("fullpop_seq", seq_bad(), 0);

    // reset mid-burst with five samples queued
    got_q.delete();
    t0 = cyc;
    num_samples = 16'd10;
    period = 16'd2;
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("mid_busy", busy, 1);
    chk("mid_valid", out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state();
    got_q.delete();
    done_cyc.delete();
    rd_cyc.delete();
    out_ready = 1'b1;
    repeat (6) step();
    chk("flush_no_output", got_q.size(), 0);
    chk("flush_no_done", done_cyc.size(), 0);
    chk("flush_no_read", rd_cyc.size(), 0);
    rd_prev = 1'b0;
    run(4, 5, -1, -1, 1'b1, -1);
    chk_burst(4, 5, 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_sample_poller.md
# wave_sample_poller

Avalon-MM read master that polls a 16-bit sample-input PIO slave at a programmable interval, buffers the captured samples in an internal FIFO and presents them on an Avalon-ST source. It sits between the waveform sample PIO (slave side, fixed read latency 1, no waitrequest) and downstream packetising logic such as the Ethernet framer. It replaces CPU polling of the PIO for burst acquisition.

## Interface

- SAMPLE_ADDR, 0: word address of the sample register in the slave.
- SAMPLE_W, 16: sample width, taken from readdata[SAMPLE_W-1:0].
- DEPTH, 16: FIFO depth in samples; power of two, minimum 4.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an acquisition when idle.
- abort  in  1  one-cycle pulse; ends the acquisition after any in-flight capture.
- num_samples  in  16  samples to acquire; sampled on accepted start.
- period  in  16  cycles between read strobes; sampled on accepted start.
- avm_address  out  2  master address; held at SAMPLE_ADDR.
- avm_read  out  1  read strobe, one cycle per sample.
- avm_readdata  in  32  slave read data, valid one cycle after avm_read.
- out_data  out  SAMPLE_W  head-of-FIFO sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts out_data when out_valid & out_ready.
- busy  out  1  acquisition in progress.
- done  out  1  one-cycle pulse at end of acquisition.
- overflow  out  1  sticky; a sample was dropped because FIFO full.
- drop_count  out  8  dropped samples, saturating at 255.

## Operation

- Reset values: avm_read 0, avm_address SAMPLE_ADDR, out_valid 0, out_data 0, busy 0, done 0, overflow 0, drop_count 0, FIFO empty, state IDLE.
- States: IDLE, READ, CAPTURE, WAIT.
- IDLE: start latches num_samples/period, clears overflow and drop_count, sets busy. num_samples = 0 → done pulse next cycle, busy stays 0, no read issued. Else → READ.
- READ: avm_read = 1 for exactly this cycle → CAPTURE.
- CAPTURE: avm_readdata[SAMPLE_W-1:0] pushed into FIFO, upper bits ignored. Captured counter increments. If count == num_samples or abort seen → IDLE with done pulse and busy cleared. Else if effective period > 2 → WAIT, else → READ.
- WAIT: down-counter from period-3 to 0, then → READ. Effective period = max(period, 2), so read strobes are exactly that many cycles apart.
- abort in READ or CAPTURE: the in-flight sample is still captured, then the block terminates. abort in WAIT: → IDLE with done next cycle. abort in IDLE: ignored.
- start while busy: ignored.
- FIFO push when full and no simultaneous pop: the sample is dropped, overflow is set, drop_count increments (saturating). The sample still counts toward num_samples.
- Push and pop in the same cycle when full: both accepted, no drop.
- Push and pop in the same cycle when empty: the push is accepted; out_valid rises next cycle.
- The FIFO keeps draining in IDLE; the acquisition FSM never blocks on out_ready.
- reset mid-operation: returns to reset values within one cycle. FIFO contents are discarded. No done pulse.

## Timing

- start accepted at cycle T: busy = 1 and avm_read = 1 at T+1, capture at T+2, out_valid = 1 at T+3 (FIFO output registered).
- Read n (0-based) is at T+1+n·max(period,2).
- done rises in the cycle after the final CAPTURE and coincides with busy falling. done is high one cycle only.
- A new start is accepted in the cycle after done.
- out_data and out_valid change only on a pop or on a push into an empty FIFO. out_data is stable while out_valid & !out_ready.

## Test plan

- Basic burst: num_samples=4, period=5, slave returns 0x1111,0x2222,0x3333,0x4444, out_ready=1 → avm_read at T+1,T+6,T+11,T+16; out stream delivers the four values in order; done at T+18; overflow=0.
- Back-to-back reads: period=0 → strobes 2 cycles apart; period=1 gives the same timing as period=0.
- Overflow: DEPTH=16, num_samples=20, period=2, out_ready=0 → FIFO holds the first 16 samples; overflow=1, drop_count=4, done asserted. Then raise out_ready → exactly 16 samples drain, out_valid falls.
- Full with simultaneous pop: FIFO full, out_ready pulsed in the capture cycle → no drop; drop_count unchanged.
- Abort and zero length: abort during WAIT of sample 3 of 10 → 3 samples captured, done the next cycle. start with num_samples=0 → done at T+1, no avm_read.
- Reset mid-burst: reset asserted while busy, with 5 samples queued → all outputs reach reset values the next cycle; the queued data is never output; a new start then behaves as in the basic burst.
